// File: rtl/acc_icb_pkg.sv
// Shared ICB widths and the outstanding-command tag carried
// from cmd accept to rsp routing.
package acc_icb_pkg;

  localparam int ICB_AW      = 32;
  localparam int ICB_DW      = 32;
  localparam int OST_DEFAULT = 4;
  localparam int CH_IDW      = 4;

  typedef struct packed {
    logic [CH_IDW-1:0] ch_id;
    logic [ICB_AW-1:0] addr;
    logic              read;
  } icb_tag_t;

endpackage

// File: rtl/icb_master_arb_n_if.sv
// Channel-side request/response bundle plus the ICB master
// port of the N-channel arbiter.
interface icb_master_arb_n_if #(
  parameter int NUM_CH = 3,
  parameter int AW     = 32,
  parameter int DW     = 32
);

  logic [NUM_CH-1:0]        ch_req_vld;
  logic [NUM_CH-1:0]        ch_req_rdy;
  logic [NUM_CH*AW-1:0]     ch_req_addr;
  logic [NUM_CH-1:0]        ch_req_read;
  logic [NUM_CH*DW-1:0]     ch_req_wdata;
  logic [NUM_CH*DW/8-1:0]   ch_req_wmask;
  logic [NUM_CH-1:0]        ch_rsp_vld;
  logic [NUM_CH-1:0]        ch_rsp_rdy;
  logic [AW-1:0]            ch_rsp_addr;
  logic [DW-1:0]            ch_rsp_data;
  logic                     ch_rsp_err;

  logic                     acc_icb_cmd_valid;
  logic                     acc_icb_cmd_ready;
  logic [AW-1:0]            acc_icb_cmd_addr;
  logic                     acc_icb_cmd_read;
  logic [DW-1:0]            acc_icb_cmd_wdata;
  logic [DW/8-1:0]          acc_icb_cmd_wmask;
  logic                     acc_icb_rsp_valid;
  logic                     acc_icb_rsp_ready;
  logic                     acc_icb_rsp_err;
  logic [DW-1:0]            acc_icb_rsp_rdata;

  modport master (
    input  ch_req_vld, ch_req_addr, ch_req_read,
    input  ch_req_wdata, ch_req_wmask, ch_rsp_rdy,
    output ch_req_rdy, ch_rsp_vld, ch_rsp_addr,
    output ch_rsp_data, ch_rsp_err,
    output acc_icb_cmd_valid, acc_icb_cmd_addr,
    output acc_icb_cmd_read, acc_icb_cmd_wdata,
    output acc_icb_cmd_wmask, acc_icb_rsp_ready,
    input  acc_icb_cmd_ready, acc_icb_rsp_valid,
    input  acc_icb_rsp_err, acc_icb_rsp_rdata
  );

  modport slave (
    output ch_req_vld, ch_req_addr, ch_req_read,
    output ch_req_wdata, ch_req_wmask, ch_rsp_rdy,
    input  ch_req_rdy, ch_rsp_vld, ch_rsp_addr,
    input  ch_rsp_data, ch_rsp_err,
    input  acc_icb_cmd_valid, acc_icb_cmd_addr,
    input  acc_icb_cmd_read, acc_icb_cmd_wdata,
    input  acc_icb_cmd_wmask, acc_icb_rsp_ready,
    output acc_icb_cmd_ready, acc_icb_rsp_valid,
    output acc_icb_rsp_err, acc_icb_rsp_rdata
  );

endinterface

// File: rtl/icb_tag_fifo.sv
// Sync FIFO of outstanding-command tags; push is refused
// when full even if a pop happens in the same cycle.
module icb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/icb_master_arb_n.sv
// N-channel round-robin ICB master with outstanding-tag
// tracking and in-order response routing.
module icb_master_arb_n
  import acc_icb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int AW      = ICB_AW,
  parameter int DW      = ICB_DW,
  parameter int MAX_OST = OST_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  icb_master_arb_n_if.master         bus,
  output logic [15:0]                err_cnt,
  output logic [$clog2(MAX_OST):0]   ost_cnt
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int MW  = DW / 8;

  logic [CHW-1:0]    rr_ptr;
  logic [CHW-1:0]    gnt;
  logic              gnt_vld;
  logic              can_load;
  logic              accept;
  logic [NUM_CH-1:0] req_rdy;

  logic              cmd_vld;
  logic [AW-1:0]     cmd_addr;
  logic              cmd_read;
  logic [DW-1:0]     cmd_wdata;
  logic [MW-1:0]     cmd_wmask;

  icb_tag_t          tag_in;
  icb_tag_t          tag_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CHW-1:0]    head_ch;
  logic [NUM_CH-1:0] rsp_vld;
  logic              rsp_ready;
  logic              rsp_pop;

  // first requester at or after rr_ptr, wrapping modulo NUM_CH
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!gnt_vld && bus.ch_req_vld[idx]) begin
        gnt_vld = 1'b1;
        gnt     = CHW'(idx);
      end
    end
  end

  assign can_load = (!cmd_vld || bus.acc_icb_cmd_ready) && !fifo_full;
  assign accept   = gnt_vld && can_load;

  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[gnt] = 1'b1;
  end

  assign bus.ch_req_rdy = req_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cmd_vld   <= 1'b0;
      cmd_addr  <= '0;
      cmd_read  <= 1'b0;
      cmd_wdata <= '0;
      cmd_wmask <= '0;
    end else if (accept) begin
      rr_ptr    <= (gnt == CHW'(NUM_CH-1)) ? '0 : gnt + 1'b1;
      cmd_vld   <= 1'b1;
      cmd_addr  <= bus.ch_req_addr[int'(gnt)*AW +: AW];
      cmd_read  <= bus.ch_req_read[gnt];
      cmd_wdata <= bus.ch_req_wdata[int'(gnt)*DW +: DW];
      cmd_wmask <= bus.ch_req_wmask[int'(gnt)*MW +: MW];
    end else if (bus.acc_icb_cmd_ready) begin
      cmd_vld   <= 1'b0;
    end
  end

  assign bus.acc_icb_cmd_valid = cmd_vld;
  assign bus.acc_icb_cmd_addr  = cmd_addr;
  assign bus.acc_icb_cmd_read  = cmd_read;
  assign bus.acc_icb_cmd_wdata = cmd_wdata;
  assign bus.acc_icb_cmd_wmask = cmd_wmask;

  always_comb begin
    tag_in       = '0;
    tag_in.ch_id = CH_IDW'(gnt);
    tag_in.addr  = ICB_AW'(bus.ch_req_addr[int'(gnt)*AW +: AW]);
    tag_in.read  = bus.ch_req_read[gnt];
  end

  icb_tag_fifo #(
    .DEPTH (MAX_OST),
    .WIDTH ($bits(icb_tag_t))
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (tag_in),
    .pop   (rsp_pop),
    .dout  (tag_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ost_cnt)
  );

  assign head_ch = tag_head.ch_id[CHW-1:0];

  // write responses are absorbed here; an unexpected rsp stalls
  always_comb begin
    rsp_vld   = '0;
    rsp_ready = 1'b0;
    if (!fifo_empty) begin
      if (tag_head.read) begin
        rsp_vld[head_ch] = bus.acc_icb_rsp_valid;
        rsp_ready        = bus.ch_rsp_rdy[head_ch];
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  assign rsp_pop               = bus.acc_icb_rsp_valid && rsp_ready;
  assign bus.acc_icb_rsp_ready = rsp_ready;
  assign bus.ch_rsp_vld        = rsp_vld;
  assign bus.ch_rsp_addr       = AW'(tag_head.addr);
  assign bus.ch_rsp_data       = bus.acc_icb_rsp_rdata;
  assign bus.ch_rsp_err        = bus.acc_icb_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (rsp_pop && bus.acc_icb_rsp_err && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_icb_master_arb_n.sv
// Directed bench for icb_master_arb_n: arbitration, cmd stall,
// outstanding limit, response routing, errors and async reset.
module tb_icb_master_arb_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] err_cnt;
  logic [2:0]  ost_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  icb_master_arb_n_if #(.NUM_CH(3), .AW(32), .DW(32)) bus ();

  icb_master_arb_n #(
    .NUM_CH(3), .AW(32), .DW(32), .MAX_OST(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .err_cnt (err_cnt),
    .ost_cnt (ost_cnt)
  );

  task automatic set_ch(input int ch, input logic [31:0] a, input logic rd,
                        input logic [31:0] wd, input logic [3:0] wm);
    bus.ch_req_addr[ch*32 +: 32] = a;
    bus.ch_req_read[ch]          = rd;
    bus.ch_req_wdata[ch*32 +: 32] = wd;
    bus.ch_req_wmask[ch*4 +: 4]  = wm;
  endtask

  task automatic test_reset();
    bus.ch_req_vld = '0; bus.ch_req_addr = '0; bus.ch_req_read = '0;
    bus.ch_req_wdata = '0; bus.ch_req_wmask = '0; bus.ch_rsp_rdy = '0;
    bus.acc_icb_cmd_ready = 1'b0; bus.acc_icb_rsp_valid = 1'b0;
    bus.acc_icb_rsp_err = 1'b0; bus.acc_icb_rsp_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.acc_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid got %b exp 0", bus.acc_icb_cmd_valid); end
    checks++; if (bus.ch_req_rdy !== 3'b000) begin errors++; $display("FAIL rst_req_rdy got %b exp 000", bus.ch_req_rdy); end
    checks++; if (bus.acc_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_ready got %b exp 0", bus.acc_icb_rsp_ready); end
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL rst_ost got %0d exp 0", ost_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err got %0d exp 0", err_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bus.acc_icb_cmd_ready = 1'b1; bus.ch_rsp_rdy = 3'b111;
    bus.acc_icb_rsp_valid = 1'b1;
    for (int c = 0; c < 3; c++) set_ch(c, 32'h1000 + c*16, 1'b1, '0, '0);
    bus.ch_req_vld = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (bus.ch_req_rdy !== 3'(1 << (i % 3))) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", i, bus.ch_req_rdy, 3'(1 << (i % 3))); end
      if (i > 0) begin
        checks++; if (bus.acc_icb_cmd_addr !== 32'h1000 + ((i-1) % 3)*16) begin errors++; $display("FAIL rr_addr%0d got %h exp %h", i, bus.acc_icb_cmd_addr, 32'h1000 + ((i-1) % 3)*16); end
      end
      @(negedge clk);
    end
    bus.ch_req_vld = '0;
    #1;
    checks++; if (bus.acc_icb_cmd_addr !== 32'h1020 || bus.acc_icb_cmd_valid !== 1'b1) begin errors++; $display("FAIL rr_last_addr got %h/%b exp 00001020/1", bus.acc_icb_cmd_addr, bus.acc_icb_cmd_valid); end
    @(negedge clk);
    bus.acc_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL rr_drain_ost got %0d exp 0", ost_cnt); end
    checks++; if (bus.acc_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL rr_cmd_idle got %b exp 0", bus.acc_icb_cmd_valid); end
  endtask

  task automatic test_write();
    set_ch(1, 32'h100, 1'b0, 32'hDEADBEEF, 4'b0011);
    bus.ch_rsp_rdy = 3'b000;
    bus.ch_req_vld = 3'b010;
    #1;
    checks++; if (bus.ch_req_rdy !== 3'b010) begin errors++; $display("FAIL wr_grant got %b exp 010", bus.ch_req_rdy); end
    @(negedge clk);
    bus.ch_req_vld = '0;
    #1;
    checks++; if (bus.acc_icb_cmd_valid !== 1'b1 || bus.acc_icb_cmd_addr !== 32'h100 || bus.acc_icb_cmd_read !== 1'b0) begin errors++; $display("FAIL wr_cmd got %b %h %b exp 1 00000100 0", bus.acc_icb_cmd_valid, bus.acc_icb_cmd_addr, bus.acc_icb_cmd_read); end
    checks++; if (bus.acc_icb_cmd_wdata !== 32'hDEADBEEF || bus.acc_icb_cmd_wmask !== 4'b0011) begin errors++; $display("FAIL wr_data got %h %b exp deadbeef 0011", bus.acc_icb_cmd_wdata, bus.acc_icb_cmd_wmask); end
    bus.acc_icb_rsp_valid = 1'b1; bus.acc_icb_rsp_err = 1'b0;
    #1;
    checks++; if (bus.acc_icb_rsp_ready !== 1'b1 || bus.ch_rsp_vld !== 3'b000) begin errors++; $display("FAIL wr_rsp got rdy %b vld %b exp 1 000", bus.acc_icb_rsp_ready, bus.ch_rsp_vld); end
    @(negedge clk);
    bus.acc_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (ost_cnt !== 3'd0 || bus.acc_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL wr_done got ost %0d cmd %b exp 0 0", ost_cnt, bus.acc_icb_cmd_valid); end
  endtask

  task automatic test_outstanding();
    set_ch(0, 32'h2000, 1'b1, '0, '0);
    bus.acc_icb_rsp_valid = 1'b0;
    bus.ch_req_vld = 3'b001;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (ost_cnt !== 3'd4) begin errors++; $display("FAIL ost_full got %0d exp 4", ost_cnt); end
    checks++; if (bus.ch_req_rdy !== 3'b000) begin errors++; $display("FAIL ost_block got %b exp 000", bus.ch_req_rdy); end
    bus.acc_icb_rsp_valid = 1'b1; bus.ch_rsp_rdy = 3'b001;
    #1;
    checks++; if (bus.ch_req_rdy !== 3'b000) begin errors++; $display("FAIL ost_no_push_on_full got %b exp 000", bus.ch_req_rdy); end
    checks++; if (bus.ch_rsp_vld !== 3'b001 || bus.acc_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL ost_rsp got vld %b rdy %b exp 001 1", bus.ch_rsp_vld, bus.acc_icb_rsp_ready); end
    @(negedge clk);
    bus.acc_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (ost_cnt !== 3'd3 || bus.ch_req_rdy !== 3'b001) begin errors++; $display("FAIL ost_fifth got ost %0d rdy %b exp 3 001", ost_cnt, bus.ch_req_rdy); end
    @(negedge clk);
    #1;
    checks++; if (ost_cnt !== 3'd4) begin errors++; $display("FAIL ost_refill got %0d exp 4", ost_cnt); end
    bus.ch_req_vld = '0; bus.acc_icb_rsp_valid = 1'b1; bus.ch_rsp_rdy = 3'b111;
    repeat (4) @(negedge clk);
    bus.acc_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL ost_drain got %0d exp 0", ost_cnt); end
  endtask

  task automatic test_routing();
    set_ch(2, 32'h20, 1'b1, '0, '0);
    bus.ch_req_vld = 3'b100;
    #1;
    checks++; if (bus.ch_req_rdy !== 3'b100) begin errors++; $display("FAIL rt_grant2 got %b exp 100", bus.ch_req_rdy); end
    @(negedge clk);
    set_ch(0, 32'h40, 1'b1, '0, '0);
    bus.ch_req_vld = 3'b001;
    #1;
    checks++; if (bus.ch_req_rdy !== 3'b001) begin errors++; $display("FAIL rt_grant0 got %b exp 001", bus.ch_req_rdy); end
    @(negedge clk);
    bus.ch_req_vld = '0;
    bus.acc_icb_rsp_valid = 1'b1; bus.acc_icb_rsp_rdata = 32'h11; bus.ch_rsp_rdy = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ch_rsp_vld !== 3'b100 || bus.acc_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL rt_stall%0d got vld %b rdy %b exp 100 0", i, bus.ch_rsp_vld, bus.acc_icb_rsp_ready); end
      checks++; if (bus.ch_rsp_addr !== 32'h20 || bus.ch_rsp_data !== 32'h11) begin errors++; $display("FAIL rt_head%0d got %h %h exp 00000020 00000011", i, bus.ch_rsp_addr, bus.ch_rsp_data); end
      @(negedge clk);
    end
    checks++; if (ost_cnt !== 3'd2) begin errors++; $display("FAIL rt_held got %0d exp 2", ost_cnt); end
    bus.ch_rsp_rdy = 3'b100;
    #1;
    checks++; if (bus.acc_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL rt_release got %b exp 1", bus.acc_icb_rsp_ready); end
    @(negedge clk);
    bus.acc_icb_rsp_rdata = 32'h22; bus.ch_rsp_rdy = 3'b001;
    #1;
    checks++; if (bus.ch_rsp_vld !== 3'b001 || bus.ch_rsp_addr !== 32'h40 || bus.ch_rsp_data !== 32'h22) begin errors++; $display("FAIL rt_second got %b %h %h exp 001 00000040 00000022", bus.ch_rsp_vld, bus.ch_rsp_addr, bus.ch_rsp_data); end
    @(negedge clk);
    bus.acc_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL rt_drain got %0d exp 0", ost_cnt); end
  endtask

  task automatic test_cmd_stall();
    set_ch(1, 32'h200, 1'b0, 32'hCAFEF00D, 4'hF);
    bus.ch_req_vld = 3'b010; bus.acc_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (bus.ch_req_rdy !== 3'b010) begin errors++; $display("FAIL st_grant got %b exp 010", bus.ch_req_rdy); end
    @(negedge clk);
    bus.acc_icb_cmd_ready = 1'b0;
    set_ch(1, 32'h300, 1'b0, 32'h12345678, 4'hF);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.acc_icb_cmd_valid !== 1'b1 || bus.acc_icb_cmd_addr !== 32'h200 || bus.acc_icb_cmd_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL st_hold%0d got %b %h %h exp 1 00000200 cafef00d", i, bus.acc_icb_cmd_valid, bus.acc_icb_cmd_addr, bus.acc_icb_cmd_wdata); end
      checks++; if (bus.ch_req_rdy !== 3'b000) begin errors++; $display("FAIL st_rdy%0d got %b exp 000", i, bus.ch_req_rdy); end
      @(negedge clk);
    end
    bus.acc_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (bus.ch_req_rdy !== 3'b010) begin errors++; $display("FAIL st_drain_rdy got %b exp 010", bus.ch_req_rdy); end
    @(negedge clk);
    set_ch(1, 32'h304, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (bus.acc_icb_cmd_addr !== 32'h300) begin errors++; $display("FAIL st_b2b1 got %h exp 00000300", bus.acc_icb_cmd_addr); end
    @(negedge clk);
    bus.ch_req_vld = '0;
    #1;
    checks++; if (bus.acc_icb_cmd_addr !== 32'h304 || ost_cnt !== 3'd3) begin errors++; $display("FAIL st_b2b2 got %h ost %0d exp 00000304 3", bus.acc_icb_cmd_addr, ost_cnt); end
    bus.acc_icb_rsp_valid = 1'b1; bus.acc_icb_rsp_err = 1'b1;
    #1;
    checks++; if (bus.ch_rsp_err !== 1'b1 || bus.acc_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL st_err_fwd got %b %b exp 1 1", bus.ch_rsp_err, bus.acc_icb_rsp_ready); end
    repeat (3) @(negedge clk);
    bus.acc_icb_rsp_valid = 1'b0; bus.acc_icb_rsp_err = 1'b0;
    #1;
    checks++; if (err_cnt !== 16'd3 || ost_cnt !== 3'd0) begin errors++; $display("FAIL st_err_cnt got %0d ost %0d exp 3 0", err_cnt, ost_cnt); end
  endtask

  task automatic test_async_reset();
    set_ch(1, 32'h3000, 1'b1, '0, '0);
    set_ch(0, 32'h4000, 1'b1, '0, '0);
    bus.ch_req_vld = 3'b010; bus.acc_icb_cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.ch_req_vld = '0;
    #1;
    checks++; if (ost_cnt !== 3'd3 || bus.acc_icb_cmd_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got ost %0d cmd %b exp 3 1", ost_cnt, bus.acc_icb_cmd_valid); end
    bus.acc_icb_rsp_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.acc_icb_cmd_valid !== 1'b0 || ost_cnt !== 3'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL ar_clear got cmd %b ost %0d err %0d exp 0 0 0", bus.acc_icb_cmd_valid, ost_cnt, err_cnt); end
    checks++; if (bus.acc_icb_rsp_ready !== 1'b0 || bus.ch_rsp_vld !== 3'b000) begin errors++; $display("FAIL ar_rsp got rdy %b vld %b exp 0 000", bus.acc_icb_rsp_ready, bus.ch_rsp_vld); end
    @(negedge clk);
    bus.acc_icb_rsp_valid = 1'b0;
    rst_n = 1'b1;
    bus.ch_req_vld = 3'b111;
    #1;
    checks++; if (bus.ch_req_rdy !== 3'b001) begin errors++; $display("FAIL ar_first_grant got %b exp 001", bus.ch_req_rdy); end
    @(negedge clk);
    bus.ch_req_vld = '0;
    #1;
    checks++; if (bus.acc_icb_cmd_addr !== 32'h4000 || bus.acc_icb_cmd_valid !== 1'b1) begin errors++; $display("FAIL ar_first_cmd got %h %b exp 00004000 1", bus.acc_icb_cmd_addr, bus.acc_icb_cmd_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_outstanding();
    test_routing();
    test_cmd_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
